shift194_ctrl: RTL and testbench

Command-driven sequencer for one 4-bit universal shift register (the team's 74LS194 model).
- Accepts one command per valid/ready handshake: clear, parallel load, N-step shift or N-step rotate.
- Drives the register's mode-select, parallel, serial and clear pins.
- Reports completion with a snapshot of the register outputs.
- Shares CP with the shift register and sits between a host FSM and the register.

---
 rtl/shift194_pkg.sv | 30 +++
 rtl/sysu_74LS194.sv | 33 +++
 rtl/shift194_ctrl.sv | 160 ++++++++++++++++
 tb/tb_shift194_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/shift194_pkg.sv
// rtl/shift194_pkg.sv - op codes, mode-select encodings and state enum for shift194_ctrl
package shift194_pkg;

  localparam logic [2:0] OP_CLEAR = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_SHR   = 3'd2;
  localparam logic [2:0] OP_SHL   = 3'd3;
  localparam logic [2:0] OP_ROR   = 3'd4;
  localparam logic [2:0] OP_ROL   = 3'd5;

  // {S1,S0} encodings of the 74LS194 mode-select pins
  typedef enum logic [1:0] {
    SEL_HOLD = 2'b00,
    SEL_SHR  = 2'b01,
    SEL_SHL  = 2'b10,
    SEL_LOAD = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Direction of a shift/rotate op; right-moving ops share S1S0=01
  function automatic sel_e shift_sel(input logic [2:0] op);
    return ((op == OP_SHR) || (op == OP_ROR)) ? SEL_SHR : SEL_SHL;
  endfunction

endpackage

// File: rtl/sysu_74LS194.sv
// rtl/sysu_74LS194.sv - 4-bit universal shift register model (74LS194)
module sysu_74LS194 (
  input  logic CP,
  input  logic CR_n,
  input  logic S1,
  input  logic S0,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  input  logic DSR,
  input  logic DSL,
  output logic QA,
  output logic QB,
  output logic QC,
  output logic QD
);

  // Right shift moves QA toward QD with DSR entering QA; left shift enters DSL at QD
  always_ff @(posedge CP or negedge CR_n) begin
    if (!CR_n) begin
      {QA, QB, QC, QD} <= 4'b0000;
    end else begin
      case ({S1, S0})
        2'b01:   {QA, QB, QC, QD} <= {DSR, QA, QB, QC};
        2'b10:   {QA, QB, QC, QD} <= {QB, QC, QD, DSL};
        2'b11:   {QA, QB, QC, QD} <= {A, B, C, D};
        default: {QA, QB, QC, QD} <= {QA, QB, QC, QD};
      endcase
    end
  end

endmodule

// File: rtl/shift194_ctrl.sv
// rtl/shift194_ctrl.sv - command sequencer driving one 74LS194 shift register
module shift194_ctrl
  import shift194_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             CP,
  input  logic             CR_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [3:0]       cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  input  logic             abort,
  input  logic [3:0]       q,
  output logic             sr_s1,
  output logic             sr_s0,
  output logic [3:0]       sr_par,
  output logic             sr_dsr,
  output logic             sr_dsl,
  output logic             sr_clr_n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             aborted,
  output logic [3:0]       result
);

  state_e           r_state;
  logic [2:0]       r_op;
  logic             r_fill;
  logic [CNT_W-1:0] r_rem;
  sel_e             r_sel;
  logic [3:0]       r_par;
  logic             r_clr_n;
  logic             r_done;
  logic             r_err;
  logic             r_aborted;
  logic [3:0]       r_result;

  sel_e             w_sel;
  logic             w_dsr;
  logic             w_dsl;

  // Command FSM: latch at acceptance, count steps in RUN, pulse done for one cycle
  always_ff @(posedge CP or negedge CR_n) begin
    if (!CR_n) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_CLEAR;
      r_fill    <= 1'b0;
      r_rem     <= '0;
      r_sel     <= SEL_HOLD;
      r_par     <= 4'b0000;
      r_clr_n   <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_aborted <= 1'b0;
      r_result  <= 4'b0000;
    end else begin
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_aborted <= 1'b0;
      r_clr_n   <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op   <= cmd_op;
            r_fill <= cmd_fill;
            r_rem  <= cmd_count;
            case (cmd_op)
              OP_LOAD: begin
                r_par   <= cmd_data;
                r_sel   <= SEL_LOAD;
                r_rem   <= CNT_W'(1);
                r_state <= ST_RUN;
              end
              OP_CLEAR: begin
                r_clr_n <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end
              OP_SHR, OP_SHL, OP_ROR, OP_ROL: begin
                if (cmd_count == '0) begin
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
                end else begin
                  r_sel   <= shift_sel(cmd_op);
                  r_state <= ST_RUN;
                end
              end
              default: begin
                r_err   <= 1'b1;
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end
            endcase
          end
        end
        ST_RUN: begin
          r_rem <= r_rem - CNT_W'(1);
          if (abort) begin
            r_sel     <= SEL_HOLD;
            r_aborted <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end else if (r_rem == CNT_W'(1)) begin
            r_sel   <= SEL_HOLD;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_result <= q;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_sel   <= SEL_HOLD;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Abort must stop the register on the very edge it is sampled, so it masks the registered select
  always_comb begin
    w_sel = r_sel;
    if ((r_state == ST_RUN) && abort) begin
      w_sel = SEL_HOLD;
    end
  end

  // Serial inputs follow the latched op; rotates feed back the bit leaving the register
  always_comb begin
    w_dsr = 1'b0;
    w_dsl = 1'b0;
    if (r_state == ST_RUN) begin
      case (r_op)
        OP_SHR:  w_dsr = r_fill;
        OP_ROR:  w_dsr = q[0];
        OP_SHL:  w_dsl = r_fill;
        OP_ROL:  w_dsl = q[3];
        default: ;
      endcase
    end
  end

  assign {sr_s1, sr_s0} = w_sel;
  assign sr_par         = r_par;
  assign sr_dsr         = w_dsr;
  assign sr_dsl         = w_dsl;
  assign sr_clr_n       = r_clr_n;
  assign cmd_ready      = (r_state == ST_IDLE);
  assign busy           = (r_state == ST_RUN);
  assign done           = r_done;
  assign err            = r_err;
  assign aborted        = r_aborted;
  assign result         = r_result;

endmodule

// File: tb/tb_shift194_ctrl.sv
// tb/tb_shift194_ctrl.sv - self-checking bench for shift194_ctrl driving a 74LS194 model
module tb_shift194_ctrl;

  logic       CP = 1'b0;
  logic       CR_n;
  logic       reg_rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic [3:0] cmd_count;
  logic       cmd_fill;
  logic       abort;
  logic [3:0] q_bus;
  logic       sr_s1, sr_s0;
  logic [3:0] sr_par;
  logic       sr_dsr, sr_dsl, sr_clr_n;
  logic       busy, done, err, aborted;
  logic [3:0] result;
  logic       qa, qb, qc, qd;

  int checks = 0;
  int errors = 0;
  logic [3:0] model_q = 4'd0;

  assign q_bus = {qa, qb, qc, qd};

  always #5 CP = ~CP;

  shift194_ctrl #(.CNT_W(4)) dut (
    .CP(CP), .CR_n(CR_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count), .cmd_fill(cmd_fill),
    .abort(abort), .q(q_bus), .sr_s1(sr_s1), .sr_s0(sr_s0), .sr_par(sr_par),
    .sr_dsr(sr_dsr), .sr_dsl(sr_dsl), .sr_clr_n(sr_clr_n), .busy(busy), .done(done),
    .err(err), .aborted(aborted), .result(result)
  );

  sysu_74LS194 u_reg (
    .CP(CP), .CR_n(sr_clr_n & reg_rst_n), .S1(sr_s1), .S0(sr_s0),
    .A(sr_par[3]), .B(sr_par[2]), .C(sr_par[1]), .D(sr_par[0]),
    .DSR(sr_dsr), .DSL(sr_dsl), .QA(qa), .QB(qb), .QC(qc), .QD(qd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One register step as plain arithmetic on the value {QA,QB,QC,QD}
  function automatic logic [3:0] model_step(input logic [3:0] v, input logic [2:0] op,
                                            input logic fill, input logic [3:0] data);
    int x;
    x = int'(v);
    case (op)
      3'd1:    return data;
      3'd2:    return 4'((fill ? 8 : 0) + x / 2);
      3'd3:    return 4'(((x * 2) % 16) + (fill ? 1 : 0));
      3'd4:    return 4'(((x % 2) * 8) + x / 2);
      3'd5:    return 4'(((x * 2) % 16) + x / 8);
      default: return v;
    endcase
  endfunction

  // Issue one command at a negedge, observe it to completion, compare against the model
  task automatic run_cmd(input logic [2:0] op, input logic [3:0] data, input int cnt,
                         input logic fill, input int abort_at);
    int runs, steps, exp_lat, lat, act, clr, selbad;
    logic exp_ab, seen_err, seen_ab;
    logic [1:0] exp_sel, sel;
    runs = (op == 3'd1) ? 1 : ((op >= 3'd2 && op <= 3'd5) ? cnt : 0);
    exp_ab = (runs > 0) && (abort_at >= 1) && (abort_at <= runs);
    steps = exp_ab ? abort_at - 1 : runs;
    exp_lat = exp_ab ? abort_at + 1 : runs + 1;
    exp_sel = (op == 3'd1) ? 2'b11 : ((op == 3'd2 || op == 3'd4) ? 2'b01 : 2'b10);
    lat = 0; act = 0; clr = 0; selbad = 0; seen_err = 1'b0; seen_ab = 1'b0;
    chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_count = 4'(cnt); cmd_fill = fill;
    @(posedge CP);
    #1;
    // keep valid high with garbage while busy; the block must not take it
    cmd_op = 3'($urandom); cmd_data = 4'($urandom); cmd_count = 4'($urandom);
    cmd_fill = 1'($urandom);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge CP);
      abort = (cyc == abort_at);
      #1;
      sel = {sr_s1, sr_s0};
      if (sel != 2'b00) begin
        act++;
        if (sel != exp_sel) selbad++;
      end
      if (!sr_clr_n) clr++;
      if (done) begin
        lat = cyc; seen_err = err; seen_ab = aborted;
        cmd_valid = 1'b0;
        break;
      end
    end
    cmd_valid = 1'b0;
    for (int s = 0; s < steps; s++) model_q = model_step(model_q, op, fill, data);
    if (op == 3'd0) model_q = 4'd0;
    @(posedge CP);
    @(negedge CP);
    abort = 1'b0;
    chk("done_latency", 32'(lat), 32'(exp_lat));
    chk("sel_active_cycles", 32'(act), 32'(steps));
    chk("sel_encoding", 32'(selbad), 32'd0);
    chk("clr_low_cycles", 32'(clr), (op == 3'd0) ? 32'd1 : 32'd0);
    chk("err_flag", 32'(seen_err), 32'(op >= 3'd6));
    chk("aborted_flag", 32'(seen_ab), 32'(exp_ab));
    chk("result", 32'(result), 32'(model_q));
    chk("q_value", 32'(q_bus), 32'(model_q));
    chk("done_cleared", 32'(done), 32'd0);
    chk("ready_after", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    CR_n = 1'b0; reg_rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 4'd0;
    cmd_count = 4'd0; cmd_fill = 1'b0; abort = 1'b0;
    #12;
    chk("rst_sel", 32'({sr_s1, sr_s0}), 32'd0);
    chk("rst_par", 32'(sr_par), 32'd0);
    chk("rst_clr_n", 32'(sr_clr_n), 32'd1);
    chk("rst_flags", 32'({busy, done, err, aborted}), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge CP);
    CR_n = 1'b1; reg_rst_n = 1'b1;
    @(negedge CP);

    // directed scenarios
    run_cmd(3'd1, 4'b1011, 0, 1'b0, 0);
    run_cmd(3'd1, 4'b1000, 0, 1'b0, 0);
    run_cmd(3'd2, 4'd0, 3, 1'b1, 0);
    run_cmd(3'd1, 4'b1000, 0, 1'b0, 0);
    run_cmd(3'd5, 4'd0, 5, 1'b0, 0);
    run_cmd(3'd3, 4'd0, 0, 1'b1, 0);
    run_cmd(3'd6, 4'd0, 7, 1'b1, 0);
    run_cmd(3'd1, 4'b0001, 0, 1'b0, 0);
    run_cmd(3'd2, 4'd0, 8, 1'b0, 3);
    run_cmd(3'd0, 4'd0, 0, 1'b0, 0);
    run_cmd(3'd1, 4'b0101, 0, 1'b0, 1);
    run_cmd(3'd4, 4'd0, 15, 1'b0, 15);

    // reset while an ROR is running: three steps land, then everything returns to reset values
    run_cmd(3'd1, 4'b0110, 0, 1'b0, 0);
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_count = 4'd10; cmd_fill = 1'b0;
    @(posedge CP);
    #1 cmd_valid = 1'b0;
    repeat (3) @(posedge CP);
    @(negedge CP);
    CR_n = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) model_q = model_step(model_q, 3'd4, 1'b0, 4'd0);
    chk("midrst_sel", 32'({sr_s1, sr_s0}), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_q", 32'(q_bus), 32'(model_q));
    @(negedge CP);
    CR_n = 1'b1;
    @(negedge CP);
    run_cmd(3'd3, 4'd0, 1, 1'b1, 0);

    // randomized commands
    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      int cnt, ab;
      op = 3'($urandom_range(0, 7));
      cnt = $urandom_range(0, 15);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 17) : 0;
      run_cmd(op, 4'($urandom), cnt, 1'($urandom), ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
